// File: rtl/weight_seq_pkg.sv
// weight_seq_pkg: FSM state encoding and default widths shared by weight_sequencer and weight_latch
package weight_seq_pkg;
  localparam int DEF_OP_W = 6;
  localparam int DEF_WGT_W = 90;
  localparam int DEF_TILE_W = 10;
  localparam int NUM_OPS = 2 ** DEF_OP_W;
  typedef enum logic [2:0] {IDLE, FETCH, ISSUE, WAIT, DONE} state_t;
endpackage

// File: rtl/weight_latch.sv
// weight_latch: holds three weight rows, reloaded only while load is high
//   clk, rst   clock, async active-high reset (clears rows)
//   load       capture d0..d2 on the next rising edge
//   d0..d2     ROM rows in; q0..q2 registered rows out
module weight_latch
  import weight_seq_pkg::*;
#(
  parameter int W = DEF_WGT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] d0,
  input  logic [W-1:0] d1,
  input  logic [W-1:0] d2,
  output logic [W-1:0] q0,
  output logic [W-1:0] q1,
  output logic [W-1:0] q2
);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      q0 <= '0;
      q1 <= '0;
      q2 <= '0;
    end else if (load) begin
      q0 <= d0;
      q1 <= d1;
      q2 <= d2;
    end
endmodule

// File: rtl/weight_sequencer.sv
// weight_sequencer: walks an opcode range, latches weight rows per opcode and issues tiles to the conv engine
//   i_clk/i_rst                 clock, async active-high reset
//   i_start/i_abort             run start (IDLE only) and sync abort to IDLE
//   i_first_op/i_last_op/i_tiles run bounds, latched on start
//   o_opcode, i_weight0..2      weight ROM address and its rows
//   o_weight0..2                rows registered during FETCH
//   o_tile_valid/i_eng_ready    tile handshake; o_tile_idx tile index
//   i_eng_done                  engine completion pulse
//   o_busy/o_done/o_err         status, done and rejected-start pulses
module weight_sequencer
  import weight_seq_pkg::*;
#(
  parameter int OP_W = DEF_OP_W,
  parameter int WGT_W = DEF_WGT_W,
  parameter int TILE_W = DEF_TILE_W
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic              i_abort,
  input  logic [OP_W-1:0]   i_first_op,
  input  logic [OP_W-1:0]   i_last_op,
  input  logic [TILE_W-1:0] i_tiles,
  output logic [OP_W-1:0]   o_opcode,
  input  logic [WGT_W-1:0]  i_weight0,
  input  logic [WGT_W-1:0]  i_weight1,
  input  logic [WGT_W-1:0]  i_weight2,
  output logic [WGT_W-1:0]  o_weight0,
  output logic [WGT_W-1:0]  o_weight1,
  output logic [WGT_W-1:0]  o_weight2,
  output logic              o_tile_valid,
  input  logic              i_eng_ready,
  output logic [TILE_W-1:0] o_tile_idx,
  input  logic              i_eng_done,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err
);
  state_t state;
  logic [OP_W-1:0] last_op;
  logic [TILE_W-1:0] tiles;
  // o_opcode doubles as the current opcode and o_tile_idx as the tile counter
  weight_latch #(.W(WGT_W)) u_latch (
    .clk(i_clk), .rst(i_rst), .load(state == FETCH),
    .d0(i_weight0), .d1(i_weight1), .d2(i_weight2),
    .q0(o_weight0), .q1(o_weight1), .q2(o_weight2)
  );
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      state <= IDLE;
      last_op <= '0;
      tiles <= '0;
      o_opcode <= '0;
      o_tile_idx <= '0;
      o_tile_valid <= 1'b0;
      o_busy <= 1'b0;
      o_done <= 1'b0;
      o_err <= 1'b0;
    end else begin
      o_done <= 1'b0;
      o_err <= 1'b0;
      if (i_abort) begin
        state <= IDLE;
        o_tile_valid <= 1'b0;
        o_busy <= 1'b0;
      end else
        case (state)
          IDLE: if (i_start) begin
            if (i_first_op > i_last_op) o_err <= 1'b1;
            else if (i_tiles == '0) begin
              state <= DONE;
              o_done <= 1'b1;
              o_busy <= 1'b1;
            end else begin
              state <= FETCH;
              o_busy <= 1'b1;
              o_opcode <= i_first_op;
              last_op <= i_last_op;
              tiles <= i_tiles;
              o_tile_idx <= '0;
            end
          end
          FETCH: begin
            state <= ISSUE;
            o_tile_valid <= 1'b1;
          end
          ISSUE: if (i_eng_ready) begin
            state <= WAIT;
            o_tile_valid <= 1'b0;
          end
          WAIT: if (i_eng_done) begin
            // tiles >= 1 is guaranteed here, so tiles-1 cannot underflow
            if (o_tile_idx < tiles - TILE_W'(1)) begin
              o_tile_idx <= o_tile_idx + TILE_W'(1);
              state <= ISSUE;
              o_tile_valid <= 1'b1;
            end else if (o_opcode == last_op) begin
              state <= DONE;
              o_done <= 1'b1;
            end else begin
              o_opcode <= o_opcode + OP_W'(1);
              o_tile_idx <= '0;
              state <= FETCH;
            end
          end
          DONE: begin
            state <= IDLE;
            o_busy <= 1'b0;
          end
          default: state <= IDLE;
        endcase
    end
endmodule
